// File: rtl/alu_control_pipe.sv
// alu_control_pipe
// Decodes a MIPS-style opcode/function pair into an ALU control word and
// hands it downstream through a single registered valid/ready stage.
// Multiply and divide optionally occupy the stage for MULT_LAT / DIV_LAT
// cycles, during which no new instruction is accepted.
//
// Optional feature: define ALU_CTRL_MULDIV_EN to decode MULT/MULTU/DIV/DIVU
// and enable the multi-cycle BUSY state. Without it those four function
// codes decode as illegal NOPs and o_busy is constant 0.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid / o_ready instruction handshake (upstream side)
//   i_op, i_func      opcode and R-type function field
//   o_valid / i_ready decode handshake (downstream side)
//   o_aluControl      ALU operation code (zero-extended to CTRL_W)
//   o_unsigned        unsigned / no-overflow-trap variant
//   o_illegal         unrecognised op/func (decoded as NOP)
//   o_busy            multi-cycle op in progress
module alu_control_pipe #(
    parameter int CTRL_W   = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_func,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_aluControl,
    output logic              o_unsigned,
    output logic              o_illegal,
    output logic              o_busy
);

    if (CTRL_W < 4 || MULT_LAT < 1 || DIV_LAT < 1) begin : g_bad_params
        $error("alu_control_pipe: CTRL_W must be >= 4 and latencies >= 1");
    end

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLL  = 4'b1001,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_MULT = 4'b1101,
        ALU_DIV  = 4'b1110,
        ALU_NOP  = 4'b1111
    } alu_code_e;

`ifdef ALU_CTRL_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BUSY} state_e;
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
`else
    typedef enum logic {S_IDLE, S_HOLD} state_e;
`endif

    alu_code_e         w_code;
    logic              w_uns;
    logic              w_ill;
    logic              w_accept;
    state_e            r_state;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_uns;
    logic              r_ill;
`ifdef ALU_CTRL_MULDIV_EN
    logic              w_muldiv;
    logic              w_div;
    logic [CNT_W-1:0]  w_lat_m1;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
`endif

    always_comb begin
        w_code = ALU_NOP;
        w_uns  = 1'b0;
        w_ill  = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        w_muldiv = 1'b0;
        w_div    = 1'b0;
`endif
        case (i_op)
            6'b000000: begin
                case (i_func)
                    6'b100000: w_code = ALU_ADD;
                    6'b100001: begin w_code = ALU_ADD; w_uns = 1'b1; end
                    6'b100010: w_code = ALU_SUB;
                    6'b100011: begin w_code = ALU_SUB; w_uns = 1'b1; end
                    6'b100100: w_code = ALU_AND;
                    6'b100101: w_code = ALU_OR;
                    6'b100110: w_code = ALU_XOR;
                    6'b100111: w_code = ALU_NOR;
                    6'b101010: w_code = ALU_SLT;
                    6'b101011: w_code = ALU_SLTU;
                    6'b000000: w_code = ALU_SLL;
                    6'b000010: w_code = ALU_SRL;
                    6'b000011: w_code = ALU_SRA;
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000: begin w_code = ALU_MULT; w_muldiv = 1'b1; end
                    6'b011001: begin w_code = ALU_MULT; w_muldiv = 1'b1; w_uns = 1'b1; end
                    6'b011010: begin w_code = ALU_DIV; w_muldiv = 1'b1; w_div = 1'b1; end
                    6'b011011: begin w_code = ALU_DIV; w_muldiv = 1'b1; w_div = 1'b1; w_uns = 1'b1; end
`endif
                    default:   w_ill = 1'b1;
                endcase
            end
            6'b001000: w_code = ALU_ADD;
            6'b001001: begin w_code = ALU_ADD; w_uns = 1'b1; end
            6'b100011: w_code = ALU_ADD;
            6'b101011: w_code = ALU_ADD;
            6'b000100: w_code = ALU_SUB;
            6'b000101: w_code = ALU_SUB;
            6'b001100: w_code = ALU_AND;
            6'b001101: w_code = ALU_OR;
            6'b001110: w_code = ALU_XOR;
            6'b001010: w_code = ALU_SLT;
            6'b001011: w_code = ALU_SLTU;
            6'b000010: w_code = ALU_NOP;
            default:   w_ill = 1'b1;
        endcase
    end

`ifdef ALU_CTRL_MULDIV_EN
    assign w_lat_m1 = w_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
    assign o_busy   = r_busy;
`else
    assign o_busy   = 1'b0;
`endif

    assign o_ready      = !o_busy && (!r_valid || i_ready);
    assign w_accept     = i_valid && o_ready;
    assign o_valid      = r_valid;
    assign o_aluControl = r_ctrl;
    assign o_unsigned   = r_uns;
    assign o_illegal    = r_ill;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ctrl  <= '1;
            r_uns   <= 1'b0;
            r_ill   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
            r_busy  <= 1'b0;
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
`ifdef ALU_CTRL_MULDIV_EN
                S_BUSY: begin
                    // Counter was loaded with LAT-1 on accept; the edge that
                    // takes it to zero is the one that presents the result.
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
`endif
                default: begin
                    if (w_accept) begin
                        r_ctrl <= CTRL_W'(w_code);
                        r_uns  <= w_uns;
                        r_ill  <= w_ill;
`ifdef ALU_CTRL_MULDIV_EN
                        if (w_muldiv && (w_lat_m1 != '0)) begin
                            r_cnt   <= w_lat_m1;
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end
`else
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
`endif
                    end else if (i_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed testbench for alu_control_pipe (CTRL_W=4, MULT_LAT=4, DIV_LAT=32).
// Observed outputs are packed as {valid, busy, ready, aluControl, unsigned, illegal}.
module tb_alu_control_pipe;

    logic       i_clk   = 1'b0;
    logic       i_rst   = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic [5:0] i_op    = '0;
    logic [5:0] i_func  = '0;
    logic       o_ready;
    logic       o_valid;
    logic [3:0] o_aluControl;
    logic       o_unsigned;
    logic       o_illegal;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] obs;
    assign obs = {o_valid, o_busy, o_ready, o_aluControl, o_unsigned, o_illegal};

    always #5 i_clk = ~i_clk;

    alu_control_pipe #(
        .CTRL_W   (4),
        .MULT_LAT (4),
        .DIV_LAT  (32)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_func       (i_func),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_aluControl (o_aluControl),
        .o_unsigned   (o_unsigned),
        .o_illegal    (o_illegal),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic       u;
        logic       ill;
    } vec_t;

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        i_valid = v;
        i_op    = op;
        i_func  = fn;
        i_ready = rdy;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (obs !== 9'b0_0_1_1111_0_0) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", obs, 9'b0_0_1_1111_0_0);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 6'b001000, 6'd0, 1'b0);
        step();
        n_vec++;
        if (obs !== 9'b1_0_0_0010_0_0) begin
            n_err++;
            $display("FAIL midstream_hold: got %b want %b", obs, 9'b1_0_0_0010_0_0);
        end
        drive(1'b0, 6'd0, 6'd0, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== 9'b0_0_1_1111_0_0) begin
            n_err++;
            $display("FAIL midstream_reset: got %b want %b", obs, 9'b0_0_1_1111_0_0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        drive(1'b1, 6'b100011, 6'd0, 1'b1);
        step();
        n_vec++;
        if (obs !== 9'b1_0_1_0010_0_0) begin
            n_err++;
            $display("FAIL lw_after_reset: got %b want %b", obs, 9'b1_0_1_0010_0_0);
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
    endtask

    task automatic test_decode_table();
        vec_t tbl [27];
        logic [8:0] exp_v;
        tbl = '{
            '{6'b001000, 6'h2A, 4'b0010, 1'b0, 1'b0},
            '{6'b001001, 6'h2A, 4'b0010, 1'b1, 1'b0},
            '{6'b100011, 6'h00, 4'b0010, 1'b0, 1'b0},
            '{6'b101011, 6'h00, 4'b0010, 1'b0, 1'b0},
            '{6'b000100, 6'h00, 4'b0110, 1'b0, 1'b0},
            '{6'b000101, 6'h00, 4'b0110, 1'b0, 1'b0},
            '{6'b001100, 6'h00, 4'b0000, 1'b0, 1'b0},
            '{6'b001101, 6'h00, 4'b0001, 1'b0, 1'b0},
            '{6'b001110, 6'h00, 4'b0011, 1'b0, 1'b0},
            '{6'b001010, 6'h00, 4'b0111, 1'b0, 1'b0},
            '{6'b001011, 6'h00, 4'b1000, 1'b0, 1'b0},
            '{6'b000010, 6'h00, 4'b1111, 1'b0, 1'b0},
            '{6'b111111, 6'h20, 4'b1111, 1'b0, 1'b1},
            '{6'b000000, 6'b100000, 4'b0010, 1'b0, 1'b0},
            '{6'b000000, 6'b100001, 4'b0010, 1'b1, 1'b0},
            '{6'b000000, 6'b100010, 4'b0110, 1'b0, 1'b0},
            '{6'b000000, 6'b100011, 4'b0110, 1'b1, 1'b0},
            '{6'b000000, 6'b100100, 4'b0000, 1'b0, 1'b0},
            '{6'b000000, 6'b100101, 4'b0001, 1'b0, 1'b0},
            '{6'b000000, 6'b100110, 4'b0011, 1'b0, 1'b0},
            '{6'b000000, 6'b100111, 4'b1100, 1'b0, 1'b0},
            '{6'b000000, 6'b101010, 4'b0111, 1'b0, 1'b0},
            '{6'b000000, 6'b101011, 4'b1000, 1'b0, 1'b0},
            '{6'b000000, 6'b000000, 4'b1001, 1'b0, 1'b0},
            '{6'b000000, 6'b000010, 4'b1010, 1'b0, 1'b0},
            '{6'b000000, 6'b000011, 4'b1011, 1'b0, 1'b0},
            '{6'b000000, 6'b000001, 4'b1111, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].op, tbl[i].fn, 1'b1);
            step();
            exp_v = {1'b1, 1'b0, 1'b1, tbl[i].code, tbl[i].u, tbl[i].ill};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL decode op=%b fn=%b: got %b want %b", tbl[i].op, tbl[i].fn, obs, exp_v);
            end
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
        n_vec++;
        if (obs[8:6] !== 3'b001) begin
            n_err++;
            $display("FAIL hold_release: got %b want %b", obs[8:6], 3'b001);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops   [4] = '{6'b001101, 6'b001010, 6'b000000, 6'b000000};
        logic [5:0] fns   [4] = '{6'b000000, 6'b000000, 6'b100111, 6'b000011};
        logic [3:0] codes [4] = '{4'b0001, 4'b0111, 4'b1100, 4'b1011};
        logic [8:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], fns[i], 1'b1);
            step();
            exp_v = {3'b101, codes[i], 2'b00};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
    endtask

    task automatic test_hold();
        drive(1'b1, 6'b000000, 6'b101010, 1'b0);
        step();
        drive(1'b1, 6'b001001, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (obs !== 9'b1_0_0_0111_0_0) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got %b want %b", i, obs, 9'b1_0_0_0111_0_0);
            end
            step();
        end
        i_ready = 1'b1;
        #1;
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_ready_comb: got %b want %b", o_ready, 1'b1);
        end
        step();
        n_vec++;
        if (obs !== 9'b1_0_1_0010_1_0) begin
            n_err++;
            $display("FAIL hold_second_accept: got %b want %b", obs, 9'b1_0_1_0010_1_0);
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
    endtask

`ifdef ALU_CTRL_MULDIV_EN
    task automatic test_multu();
        drive(1'b1, 6'b000000, 6'b011001, 1'b1);
        step();
        drive(1'b1, 6'b001000, 6'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs !== 9'b0_1_0_1101_1_0) begin
                n_err++;
                $display("FAIL multu_busy[%0d]: got %b want %b", i, obs, 9'b0_1_0_1101_1_0);
            end
            step();
        end
        n_vec++;
        if (obs !== 9'b1_0_1_1101_1_0) begin
            n_err++;
            $display("FAIL multu_done: got %b want %b", obs, 9'b1_0_1_1101_1_0);
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
        n_vec++;
        if (obs[8:6] !== 3'b001) begin
            n_err++;
            $display("FAIL multu_release: got %b want %b", obs[8:6], 3'b001);
        end
    endtask

    task automatic test_div_reset();
        int seen;
        drive(1'b1, 6'b000000, 6'b011010, 1'b1);
        step();
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (obs !== 9'b0_1_0_1110_0_0) begin
                n_err++;
                $display("FAIL div_busy[%0d]: got %b want %b", i, obs, 9'b0_1_0_1110_0_0);
            end
            if (i < 9) step();
        end
        #2 i_rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== 9'b0_0_1_1111_0_0) begin
            n_err++;
            $display("FAIL div_abort_reset: got %b want %b", obs, 9'b0_0_1_1111_0_0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_valid || o_busy) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL div_no_valid_after_abort: got %0d want %0d", seen, 0);
        end
        drive(1'b1, 6'b111111, 6'd0, 1'b1);
        step();
        n_vec++;
        if (obs !== 9'b1_0_1_1111_0_1) begin
            n_err++;
            $display("FAIL illegal_after_abort: got %b want %b", obs, 9'b1_0_1_1111_0_1);
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
    endtask
`else
    task automatic test_muldiv_disabled();
        logic [5:0] fns [4] = '{6'b011010, 6'b011000, 6'b011001, 6'b011011};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'b000000, fns[i], 1'b1);
            step();
            n_vec++;
            if (obs !== 9'b1_0_1_1111_0_1) begin
                n_err++;
                $display("FAIL muldiv_disabled fn=%b: got %b want %b", fns[i], obs, 9'b1_0_1_1111_0_1);
            end
        end
        drive(1'b0, 6'd0, 6'd0, 1'b1);
        step();
    endtask
`endif

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        test_reset();
        test_reset_midstream();
        test_decode_table();
        test_back_to_back();
        test_hold();
`ifdef ALU_CTRL_MULDIV_EN
        test_multu();
        test_div_reset();
`else
        test_muldiv_disabled();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
